// File: rtl/sspac_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU op codes, register-zero index, widths.
package sspac_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned RW_DEFAULT = 5;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_DIV  = 3'b101;
  localparam logic [2:0] ALU_ZERO = 3'b110;
  localparam logic [2:0] ALU_MUL  = 3'b111;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic signext);
    return signext ? {{16{imm[15]}}, imm} : {16'b0, imm};
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side inputs, forwarding sources and ALU-side outputs of the ID/EX operand stage.
interface id_ex_operand_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  logic          stall;
  logic          flush;
  logic          id_valid;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [15:0]   id_imm;
  logic          id_signext;
  logic          id_alusrc;
  logic [2:0]    id_aluop;
  logic          id_regwrite;
  logic          mem_regwrite;
  logic [RW-1:0] mem_rd;
  logic [DW-1:0] mem_result;
  logic          wb_regwrite;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic [2:0]    op;
  logic          ex_valid;
  logic          ex_regwrite;
  logic [RW-1:0] ex_rd;
  logic [DW-1:0] ex_store_data;

  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_rd, id_imm,
           id_signext, id_alusrc, id_aluop, id_regwrite, mem_regwrite, mem_rd, mem_result,
           wb_regwrite, wb_rd, wb_data,
    input  op1, op2, op, ex_valid, ex_regwrite, ex_rd, ex_store_data
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_rd, id_imm,
           id_signext, id_alusrc, id_aluop, id_regwrite, mem_regwrite, mem_rd, mem_result,
           wb_regwrite, wb_rd, wb_data,
    output op1, op2, op, ex_valid, ex_regwrite, ex_rd, ex_store_data
  );
endinterface

// File: rtl/forward_mux.sv
// Selects the freshest value for one source register: EX/MEM result, then MEM/WB, then stored.
module forward_mux
  import sspac_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned RW = RW_DEFAULT
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] stored,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data,
  output logic          wb_hit
);

  logic not_zero;
  logic mem_hit;

  assign not_zero = (idx != RW'(REG_ZERO));
  assign mem_hit  = mem_regwrite && (mem_rd == idx) && not_zero;
  assign wb_hit   = wb_regwrite && (wb_rd == idx) && not_zero;

  // MEM is the younger result, so it outranks WB on a double match.
  always_comb begin
    data = stored;
    if (mem_hit) begin
      data = mem_result;
    end else if (wb_hit) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with stall/flush and EX/MEM, MEM/WB operand forwarding into the ALU.
module id_ex_operand_stage
  import sspac_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned RW = RW_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  id_ex_operand_stage_if.slave bus
);

  logic          valid_q;
  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [RW-1:0] rs_q;
  logic [RW-1:0] rt_q;
  logic [RW-1:0] rd_q;
  logic [31:0]   ext_imm_q;
  logic          alusrc_q;
  logic [2:0]    aluop_q;
  logic          regwrite_q;

  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;
  logic          rs_wb_hit;
  logic          rt_wb_hit;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q    <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      ext_imm_q  <= '0;
      alusrc_q   <= 1'b0;
      aluop_q    <= 3'b000;
      regwrite_q <= 1'b0;
    end else if (bus.stall) begin
      // Capture a WB result retiring mid-stall; it will be gone once the stall releases.
      if (rs_wb_hit) rs_data_q <= bus.wb_data;
      if (rt_wb_hit) rt_data_q <= bus.wb_data;
    end else begin
      valid_q    <= bus.id_valid;
      rs_data_q  <= bus.id_rs_data;
      rt_data_q  <= bus.id_rt_data;
      rs_q       <= bus.id_rs;
      rt_q       <= bus.id_rt;
      rd_q       <= bus.id_rd;
      ext_imm_q  <= extend_imm(bus.id_imm, bus.id_signext);
      alusrc_q   <= bus.id_alusrc;
      aluop_q    <= bus.id_aluop;
      regwrite_q <= bus.id_regwrite;
    end
  end

  forward_mux #(
    .DW(DW),
    .RW(RW)
  ) u_fwd_rs (
    .idx          (rs_q),
    .stored       (rs_data_q),
    .mem_regwrite (bus.mem_regwrite),
    .mem_rd       (bus.mem_rd),
    .mem_result   (bus.mem_result),
    .wb_regwrite  (bus.wb_regwrite),
    .wb_rd        (bus.wb_rd),
    .wb_data      (bus.wb_data),
    .data         (rs_fwd),
    .wb_hit       (rs_wb_hit)
  );

  forward_mux #(
    .DW(DW),
    .RW(RW)
  ) u_fwd_rt (
    .idx          (rt_q),
    .stored       (rt_data_q),
    .mem_regwrite (bus.mem_regwrite),
    .mem_rd       (bus.mem_rd),
    .mem_result   (bus.mem_result),
    .wb_regwrite  (bus.wb_regwrite),
    .wb_rd        (bus.wb_rd),
    .wb_data      (bus.wb_data),
    .data         (rt_fwd),
    .wb_hit       (rt_wb_hit)
  );

  assign bus.op1           = rs_fwd;
  assign bus.op2           = alusrc_q ? DW'(ext_imm_q) : rt_fwd;
  assign bus.op            = aluop_q;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_regwrite   = regwrite_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_store_data = rt_fwd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, load, immediates, forwarding, stall, flush.
module tb_id_ex_operand_stage;
  import sspac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   asserts = 0;
  int   fails = 0;

  id_ex_operand_stage_if #(.DW(32), .RW(5)) bus ();

  id_ex_operand_stage #(
    .DW(32),
    .RW(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_rs_data = '0; bus.id_rt_data = '0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_imm = '0; bus.id_signext = 0; bus.id_alusrc = 0;
    bus.id_aluop = 3'b000; bus.id_regwrite = 0;
    bus.mem_regwrite = 0; bus.mem_rd = '0; bus.mem_result = '0;
    bus.wb_regwrite = 0; bus.wb_rd = '0; bus.wb_data = '0;
  endtask

  task automatic load(input logic [2:0] aluop, input logic [4:0] rs, input logic [31:0] rsd,
                      input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd);
    bus.id_valid = 1; bus.id_regwrite = 1; bus.id_aluop = aluop;
    bus.id_rs = rs; bus.id_rs_data = rsd; bus.id_rt = rt; bus.id_rt_data = rtd;
    bus.id_rd = rd; bus.id_alusrc = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    load(ALU_MUL, 5'd7, 32'hDEAD, 5'd8, 32'hBEEF, 5'd9);
    rst = 1;
    tick();
    rst = 0;
    clear_inputs();
    #1;
    asserts++; if (bus.op1 !== 32'd0) begin fails++; $display("FAIL reset_op1 got %h want 0", bus.op1); end
    asserts++; if (bus.op2 !== 32'd0) begin fails++; $display("FAIL reset_op2 got %h want 0", bus.op2); end
    asserts++; if (bus.op !== 3'b000) begin fails++; $display("FAIL reset_op got %b want 000", bus.op); end
    asserts++; if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.ex_valid); end
    asserts++; if (bus.ex_regwrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite got %b want 0", bus.ex_regwrite); end
    asserts++; if (bus.ex_rd !== 5'd0) begin fails++; $display("FAIL reset_rd got %0d want 0", bus.ex_rd); end
    asserts++; if (bus.ex_store_data !== 32'd0) begin fails++; $display("FAIL reset_store got %h want 0", bus.ex_store_data); end
  endtask

  task automatic test_load();
    load(ALU_ADD, 5'd3, 32'd5, 5'd4, 32'd7, 5'd10);
    tick();
    asserts++; if (bus.op1 !== 32'd5) begin fails++; $display("FAIL load_op1 got %0d want 5", bus.op1); end
    asserts++; if (bus.op2 !== 32'd7) begin fails++; $display("FAIL load_op2 got %0d want 7", bus.op2); end
    asserts++; if (bus.op !== 3'b010) begin fails++; $display("FAIL load_op got %b want 010", bus.op); end
    asserts++; if (bus.ex_valid !== 1'b1) begin fails++; $display("FAIL load_valid got %b want 1", bus.ex_valid); end
    asserts++; if (bus.ex_regwrite !== 1'b1) begin fails++; $display("FAIL load_regwrite got %b want 1", bus.ex_regwrite); end
    asserts++; if (bus.ex_rd !== 5'd10) begin fails++; $display("FAIL load_rd got %0d want 10", bus.ex_rd); end
    asserts++; if (bus.ex_store_data !== 32'd7) begin fails++; $display("FAIL load_store got %0d want 7", bus.ex_store_data); end
  endtask

  task automatic test_imm();
    load(ALU_ADD, 5'd3, 32'd5, 5'd4, 32'd7, 5'd10);
    bus.id_alusrc = 1; bus.id_imm = 16'hFFFE; bus.id_signext = 1;
    tick();
    asserts++; if (bus.op2 !== 32'hFFFFFFFE) begin fails++; $display("FAIL imm_sext got %h want fffffffe", bus.op2); end
    asserts++; if (bus.ex_store_data !== 32'd7) begin fails++; $display("FAIL imm_store got %h want 7", bus.ex_store_data); end
    bus.id_signext = 0;
    tick();
    asserts++; if (bus.op2 !== 32'h0000FFFE) begin fails++; $display("FAIL imm_zext got %h want 0000fffe", bus.op2); end
    bus.id_imm = 16'h7FFF; bus.id_signext = 1;
    tick();
    asserts++; if (bus.op2 !== 32'h00007FFF) begin fails++; $display("FAIL imm_sext_pos got %h want 00007fff", bus.op2); end
  endtask

  task automatic test_forward();
    load(ALU_ADD, 5'd3, 32'd11, 5'd4, 32'd7, 5'd10);
    tick();
    bus.mem_regwrite = 1; bus.mem_rd = 5'd3; bus.mem_result = 32'd100;
    bus.wb_regwrite = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'd200;
    #1;
    asserts++; if (bus.op1 !== 32'd100) begin fails++; $display("FAIL fwd_mem_wins got %0d want 100", bus.op1); end
    asserts++; if (bus.op2 !== 32'd7) begin fails++; $display("FAIL fwd_rt_untouched got %0d want 7", bus.op2); end
    bus.mem_regwrite = 0;
    #1;
    asserts++; if (bus.op1 !== 32'd200) begin fails++; $display("FAIL fwd_wb got %0d want 200", bus.op1); end
    bus.wb_rd = 5'd4; bus.wb_data = 32'd44;
    #1;
    asserts++; if (bus.ex_store_data !== 32'd44) begin fails++; $display("FAIL fwd_wb_store got %0d want 44", bus.ex_store_data); end
    // Register zero: stored data must win even with both sources naming r0.
    load(ALU_ADD, 5'd0, 32'd11, 5'd4, 32'd7, 5'd10);
    bus.mem_regwrite = 0; bus.wb_regwrite = 0;
    tick();
    bus.mem_regwrite = 1; bus.mem_rd = 5'd0; bus.mem_result = 32'd100;
    bus.wb_regwrite = 1; bus.wb_rd = 5'd0; bus.wb_data = 32'd200;
    #1;
    asserts++; if (bus.op1 !== 32'd11) begin fails++; $display("FAIL fwd_r0 got %0d want 11", bus.op1); end
    // rs == rt: both operands see the same forward.
    load(ALU_SUB, 5'd8, 32'd20, 5'd8, 32'd20, 5'd1);
    bus.mem_regwrite = 0; bus.wb_regwrite = 0;
    tick();
    bus.mem_regwrite = 1; bus.mem_rd = 5'd8; bus.mem_result = 32'd77;
    #1;
    asserts++; if (bus.op1 !== 32'd77) begin fails++; $display("FAIL fwd_same_op1 got %0d want 77", bus.op1); end
    asserts++; if (bus.op2 !== 32'd77) begin fails++; $display("FAIL fwd_same_op2 got %0d want 77", bus.op2); end
    clear_inputs();
  endtask

  task automatic test_stall_refresh();
    load(ALU_SUB, 5'd2, 32'd3, 5'd6, 32'd1, 5'd12);
    tick();
    bus.stall = 1;
    load(ALU_MUL, 5'd9, 32'd999, 5'd9, 32'd999, 5'd13);
    bus.wb_regwrite = 1; bus.wb_rd = 5'd6; bus.wb_data = 32'd55;
    bus.mem_regwrite = 1; bus.mem_rd = 5'd2; bus.mem_result = 32'd99;
    #1;
    asserts++; if (bus.op2 !== 32'd55) begin fails++; $display("FAIL stall_c1_op2 got %0d want 55", bus.op2); end
    asserts++; if (bus.op1 !== 32'd99) begin fails++; $display("FAIL stall_c1_op1 got %0d want 99", bus.op1); end
    asserts++; if (bus.op !== ALU_SUB) begin fails++; $display("FAIL stall_c1_op got %b want 011", bus.op); end
    tick();
    bus.wb_regwrite = 0; bus.mem_regwrite = 0;
    #1;
    asserts++; if (bus.op2 !== 32'd55) begin fails++; $display("FAIL stall_c2_op2 got %0d want 55", bus.op2); end
    asserts++; if (bus.op1 !== 32'd3) begin fails++; $display("FAIL stall_no_mem_wb got %0d want 3", bus.op1); end
    asserts++; if (bus.op !== ALU_SUB) begin fails++; $display("FAIL stall_c2_op got %b want 011", bus.op); end
    asserts++; if (bus.ex_rd !== 5'd12) begin fails++; $display("FAIL stall_rd got %0d want 12", bus.ex_rd); end
    tick();
    asserts++; if (bus.ex_store_data !== 32'd55) begin fails++; $display("FAIL stall_c3_store got %0d want 55", bus.ex_store_data); end
    bus.stall = 0;
  endtask

  task automatic test_flush_vs_stall();
    load(ALU_OR, 5'd5, 32'd50, 5'd6, 32'd60, 5'd7);
    tick();
    bus.stall = 1; bus.flush = 1;
    tick();
    bus.stall = 0; bus.flush = 0;
    clear_inputs();
    #1;
    asserts++; if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", bus.ex_valid); end
    asserts++; if (bus.ex_regwrite !== 1'b0) begin fails++; $display("FAIL flush_regwrite got %b want 0", bus.ex_regwrite); end
    asserts++; if (bus.op !== 3'b000) begin fails++; $display("FAIL flush_op got %b want 000", bus.op); end
    asserts++; if (bus.op1 !== 32'd0) begin fails++; $display("FAIL flush_op1 got %0d want 0", bus.op1); end
    asserts++; if (bus.op2 !== 32'd0) begin fails++; $display("FAIL flush_op2 got %0d want 0", bus.op2); end
    asserts++; if (bus.ex_rd !== 5'd0) begin fails++; $display("FAIL flush_rd got %0d want 0", bus.ex_rd); end
  endtask

  task automatic test_reset_mid_stall();
    load(ALU_ADD, 5'd1, 32'd10, 5'd2, 32'd20, 5'd5);
    tick();
    bus.stall = 1;
    load(ALU_AND, 5'd3, 32'd30, 5'd4, 32'd40, 5'd6);
    tick();
    asserts++; if (bus.ex_valid !== 1'b1) begin fails++; $display("FAIL hold_valid got %b want 1", bus.ex_valid); end
    asserts++; if (bus.op1 !== 32'd10) begin fails++; $display("FAIL hold_op1 got %0d want 10", bus.op1); end
    rst = 1;
    tick();
    rst = 0; bus.stall = 0;
    clear_inputs();
    #1;
    asserts++; if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL rststall_valid got %b want 0", bus.ex_valid); end
    asserts++; if (bus.op1 !== 32'd0) begin fails++; $display("FAIL rststall_op1 got %0d want 0", bus.op1); end
    asserts++; if (bus.op2 !== 32'd0) begin fails++; $display("FAIL rststall_op2 got %0d want 0", bus.op2); end
    asserts++; if (bus.op !== 3'b000) begin fails++; $display("FAIL rststall_op got %b want 000", bus.op); end
    asserts++; if (bus.ex_rd !== 5'd0) begin fails++; $display("FAIL rststall_rd got %0d want 0", bus.ex_rd); end
  endtask

  task automatic test_back_to_back();
    load(ALU_OR, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3);
    tick();
    asserts++; if (bus.op !== ALU_OR) begin fails++; $display("FAIL b2b_a_op got %b want 001", bus.op); end
    asserts++; if (bus.op1 !== 32'd1) begin fails++; $display("FAIL b2b_a_op1 got %0d want 1", bus.op1); end
    load(ALU_SLT, 5'd4, 32'd40, 5'd2, 32'd2, 5'd7);
    bus.id_alusrc = 1; bus.id_imm = 16'd5; bus.id_signext = 0;
    tick();
    asserts++; if (bus.op !== ALU_SLT) begin fails++; $display("FAIL b2b_b_op got %b want 100", bus.op); end
    asserts++; if (bus.op1 !== 32'd40) begin fails++; $display("FAIL b2b_b_op1 got %0d want 40", bus.op1); end
    asserts++; if (bus.op2 !== 32'd5) begin fails++; $display("FAIL b2b_b_op2 got %0d want 5", bus.op2); end
    asserts++; if (bus.ex_rd !== 5'd7) begin fails++; $display("FAIL b2b_b_rd got %0d want 7", bus.ex_rd); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load();
    test_imm();
    test_forward();
    test_stall_refresh();
    test_flush_vs_stall();
    test_reset_mid_stall();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU. It captures decoded operands and control from the decode stage on each clock. It resolves read-after-write hazards by forwarding results from the EX/MEM and MEM/WB stages, and drives the ALU's `OP1`, `OP2` and `OP` inputs. It also supports stall (hold) and flush (bubble insertion) for the hazard unit.

## Interface
Parameters:
- `DW`, 32: datapath width.
- `RW`, 5: register-index width.

Ports:
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `STALL`  in  1: hold current contents.
- `FLUSH`  in  1: load a bubble.
- `ID_VALID`  in  1: decode stage holds a real instruction.
- `ID_RS_DATA`, `ID_RT_DATA`  in  DW: register-file read data.
- `ID_RS`, `ID_RT`, `ID_RD`  in  RW: source and destination indices.
- `ID_IMM`  in  16: raw immediate.
- `ID_SIGNEXT`  in  1: 1 = sign-extend `ID_IMM`, 0 = zero-extend.
- `ID_ALUSRC`  in  1: 1 = `OP2` takes the immediate.
- `ID_ALUOP`  in  3: ALU operation code.
- `ID_REGWRITE`  in  1: instruction writes `ID_RD`.
- `MEM_REGWRITE`  in  1, `MEM_RD`  in  RW, `MEM_RESULT`  in  DW: EX/MEM forwarding source.
- `WB_REGWRITE`  in  1, `WB_RD`  in  RW, `WB_DATA`  in  DW: MEM/WB forwarding source.
- `OP1`, `OP2`  out  DW: ALU operands.
- `OP`  out  3: ALU operation.
- `EX_VALID`, `EX_REGWRITE`  out  1: control passed downstream.
- `EX_RD`  out  RW: destination index.
- `EX_STORE_DATA`  out  DW: forwarded rt value, used for stores.

## Operation
- Registered state: valid, rs/rt data, rs/rt/rd indices, extended immediate (32 bits), alusrc, aluop, regwrite.
- Capture priority on each edge, highest first:
  - `RST`: clear all state to 0.
  - `FLUSH`: load a bubble. valid=0, regwrite=0, aluop=000, all data and indices 0.
  - `STALL`: hold all state, except data refresh (below).
  - Otherwise: load all `ID_*` inputs.
- Immediate extension at capture: `{{16{ID_IMM[15]}},ID_IMM}` if `ID_SIGNEXT`, else `{16'b0,ID_IMM}`.
- Forwarding, combinational, applied separately to stored rs and stored rt:
  - If `MEM_REGWRITE` and `MEM_RD`==idx and idx≠0: `MEM_RESULT`.
  - Else if `WB_REGWRITE` and `WB_RD`==idx and idx≠0: `WB_DATA`.
  - Else the stored data.
- Outputs:
  - `OP1` = fwd(rs).
  - `OP2` = alusrc ? ext_imm : fwd(rt).
  - `EX_STORE_DATA` = fwd(rt), regardless of alusrc.
  - `OP` = stored aluop.
- Data refresh during stall: while `STALL`=1 and `FLUSH`=0, stored rs/rt data is overwritten with the WB-forwarded value whenever the WB match condition holds. This prevents a result from being lost when it retires during the stall. MEM forwarding is not written back.
- Register 0 is never forwarded. Its stored value is used as-is.
- When valid=0, `OP1`/`OP2` are don't-care for correctness, but the bubble's zeroed contents must make them 0 unless a forward hits index 0, which it cannot.

## Timing
- Reset values: `OP1`=0, `OP2`=0, `OP`=000, `EX_VALID`=0, `EX_REGWRITE`=0, `EX_RD`=0, `EX_STORE_DATA`=0.
  - Exception: a forward match cannot occur after reset because all indices are 0.
- Latency: `ID_*` sampled at edge N appear on the outputs after edge N. Forwarding adds no cycles; it is combinational from the `MEM_*`/`WB_*` inputs.
- `FLUSH` and `STALL` together: flush wins.
- `RST` overrides both.
- `RST` asserted mid-stall: state is cleared on that edge. No hold.
- Same index matched by both MEM and WB: MEM wins, as it is the younger result.
- rs==rt: both operands receive the same forwarded value.

## Structure
- Shared package `sspac_pkg`:
  - ALU op localparams: AND=000, OR=001, ADD=010, SUB=011, SLT=100, DIV=101, ZERO=110, MUL=111.
  - `REG_ZERO`=5'd0.
  - `DW`/`RW` defaults.
- Sub-module `forward_mux`:
  - Inputs: idx, stored data, MEM triple, WB triple.
  - Outputs: selected data and a wb_hit flag, used for the stall refresh.
  - Instantiated twice (rs, rt).

## Test plan
- Reset then idle:
  - `RST`=1 for one edge → all outputs 0.
  - Release, load ADD rs=3 (data 5), rt=4 (data 7), no forwards → after one edge `OP1`=5, `OP2`=7, `OP`=010, `EX_VALID`=1.
- Immediate select:
  - `ID_ALUSRC`=1, `ID_IMM`=16'hFFFE, `ID_SIGNEXT`=1 → `OP2`=32'hFFFFFFFE.
  - Same with `ID_SIGNEXT`=0 → `OP2`=32'h0000FFFE.
- Forward priority:
  - Stored rs=3, `MEM_RD`=3 with `MEM_RESULT`=100, `WB_RD`=3 with `WB_DATA`=200, both regwrite=1 → `OP1`=100.
  - Drop `MEM_REGWRITE` → `OP1`=200.
  - Repeat with rs=0 → `OP1` = stored value, no forward.
- Stall refresh:
  - Stall 2 cycles with rt=6 stored as 1.
  - In cycle 1, WB writes 6 with 55; in cycle 2, no WB.
  - → `OP2`=55 in both cycles, `OP` unchanged.
- Flush vs stall:
  - `FLUSH`=`STALL`=1 on one edge → `EX_VALID`=0, `EX_REGWRITE`=0, `OP`=000, `OP1`=`OP2`=0.
- Reset mid-stall:
  - `STALL`=1 with valid instruction held, then `RST`=1 for one edge → all outputs 0 next cycle.
